counter_run_arbiter: RTL and testbench
======================================

# counter_run_arbiter

Controller that shares one WIDTH-bit binary up-counter between two requesters. It arbitrates requests round-robin and latches the winner's run length. It then sequences the counter through clear, count and terminate phases, and reports completion or abort per requester. It sits between requester FSMs and any logic that consumes the count value `y`.

## Interface
- `WIDTH`, default 4: counter and run-length width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester run request, level. Held high until the matching `done` bit.
- `len0`  in  WIDTH  run length for requester 0. 0 means 2^WIDTH.
- `len1`  in  WIDTH  run length for requester 1. 0 means 2^WIDTH.
- `grant`  out  2  one-hot owner of the counter. 00 when free.
- `y`  out  WIDTH  counter value.
- `valid`  out  1  high while `y` is a live count (RUN state only).
- `done`  out  2  one-cycle completion pulse to the owner.
- `aborted`  out  1  qualifies `done`: 1 means the run was ended early.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, RUN, DONE, encoded in 2 bits.
- Reset (async, `reset`=0) forces:
  - state IDLE, with `grant`, `y`, `valid`, `done`, `aborted`, `busy` all 0.
  - round-robin pointer `last` = 1, so requester 0 wins the first arbitration.
- IDLE:
  - No `req` bit set: stay in IDLE.
  - Exactly one bit set: grant that requester.
  - Both bits set: grant the requester not equal to `last`.
  - On a grant: latch the winner's `len` into `len_q`, set `grant`, go to CLEAR.
- CLEAR (1 cycle):
  - `y` <= 0.
  - If the owner's `req` is still high, go to RUN; otherwise go to DONE with the abort flag set.
- RUN:
  - `valid`=1. `y` shows 0, 1, 2, … on successive cycles, incrementing mod 2^WIDTH.
  - Terminal cycle: `y` == (`len_q` − 1) mod 2^WIDTH. This makes `len_q`=0 produce 2^WIDTH cycles ending at all-ones.
  - On the terminal cycle, go to DONE with abort clear. `y` holds its value and does not advance.
  - If the owner's `req` is sampled low in any RUN cycle, go to DONE with abort set. `y` holds its value.
  - Terminal cycle and `req` low together: abort wins.
- DONE (1 cycle):
  - Outputs: `done[owner]`=1, `aborted`=abort flag, `grant` still asserted, `valid`=0.
  - Next edge: `last` <= owner, `grant` <= 0, state IDLE.
- `y` holds its last value through DONE and IDLE until the next CLEAR.
- Changes to `len0`/`len1` after the latch have no effect on the current run.
- The non-owner's `req` is ignored until IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from `req` to any output.

## Timing
- Edge E: `req` sampled in IDLE. In the cycle after E, `grant` is set and state is CLEAR.
- RUN lasts exactly `len_q` cycles (2^WIDTH when `len_q`=0), with `valid`=1 throughout.
- `done` is a 1-cycle pulse in the cycle after the last RUN cycle.
- Request to idle: `len_q`+3 cycles in total (CLEAR + RUN + DONE + 1 IDLE).
- Gap between runs: at least 1 IDLE cycle between consecutive grants, so `grant` is never held across back-to-back runs.
- Abort timing: `req` low sampled at edge T puts DONE in the cycle after T.
- Reset mid-run: all outputs clear immediately, without waiting for a clock edge. No `done` pulse is generated for the killed run.

## Test plan
- Reset values:
  - Stimulus: hold `reset`=0 for 3 cycles with `req`=11.
  - Response: all outputs 0. After release, `grant`=01 (requester 0 wins).
- Single run:
  - Stimulus: `req`=01, `len0`=3.
  - Response: CLEAR for 1 cycle; then `valid`=1 with `y`=0,1,2; then `done`=01, `aborted`=0 for 1 cycle; then `grant`=00, `y`=2 held.
- Round-robin:
  - Stimulus: `req`=11 held throughout, `len0`=`len1`=2. Each requester re-raises its `req` after its own `done`.
  - Response: grants alternate 01, 10, 01, 10, each separated by at least 1 cycle with `grant`=00.
- Full wrap:
  - Stimulus: WIDTH=4, `len1`=0, `req`=10.
  - Response: 16 `valid` cycles with `y`=0…15; `done`=10 after `y`=15; `y` holds 15.
- Abort:
  - Stimulus: `len0`=8; drop `req[0]` at the edge after `y`=2 is shown.
  - Response: next cycle `done`=01, `aborted`=1, `y`=2 held; then IDLE.
- Reset mid-run:
  - Stimulus: assert `reset` while `y`=5.
  - Response: `grant`, `y`, `valid`, `busy` go to 0 asynchronously; no `done` pulse. After release with `req`=11, requester 0 is granted.

Source files
------------

// File: rtl/counter_run_arbiter.sv
// rtl/counter_run_arbiter.sv - round-robin shared up-counter with clear/run/done sequencing
module counter_run_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic [1:0]       done,
  output logic             aborted,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             abort_q;
  logic [WIDTH-1:0] len_q;
  logic             winner;
  logic             owner_req;
  logic [WIDTH-1:0] term_value;

  // len_q of 0 wraps to all-ones, giving a full 2^WIDTH-cycle run
  assign term_value = len_q - WIDTH'(1);
  assign owner_req  = owner ? req[1] : req[0];

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      abort_q <= 1'b0;
      len_q   <= '0;
      grant   <= 2'b00;
      y       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner <= winner;
            len_q <= winner ? len1 : len0;
            grant <= winner ? 2'b10 : 2'b01;
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          y <= '0;
          if (owner_req) begin
            abort_q <= 1'b0;
            state   <= ST_RUN;
          end else begin
            abort_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_RUN: begin
          // a dropped request takes priority over the terminal count
          if (!owner_req) begin
            abort_q <= 1'b1;
            state   <= ST_DONE;
          end else if (y == term_value) begin
            abort_q <= 1'b0;
            state   <= ST_DONE;
          end else begin
            y <= y + WIDTH'(1);
          end
        end
        ST_DONE: begin
          last  <= owner;
          grant <= 2'b00;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign valid   = (state == ST_RUN);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) ? grant : 2'b00;
  assign aborted = (state == ST_DONE) && abort_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// tb/tb_counter_run_arbiter.sv - directed vector bench for counter_run_arbiter
module tb_counter_run_arbiter;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] grant;
  logic [3:0] y;
  logic       valid;
  logic [1:0] done;
  logic       aborted;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] grant;
    logic [3:0] y;
    logic       valid;
    logic [1:0] done;
    logic       aborted;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  counter_run_arbiter #(.WIDTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .len0(len0),
    .len1(len1),
    .grant(grant),
    .y(y),
    .valid(valid),
    .done(done),
    .aborted(aborted),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] g, input logic [3:0] ey, input logic v,
                     input logic [1:0] d, input logic ab, input logic bz);
    vec_t t;
    t.req = r; t.len0 = a; t.len1 = b;
    t.grant = g; t.y = ey; t.valid = v; t.done = d; t.aborted = ab; t.busy = bz;
    vecs.push_back(t);
  endtask

  task automatic step(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b);
    @(negedge clock);
    req = r; len0 = a; len1 = b;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] g, input logic [3:0] ey,
                     input logic v, input logic [1:0] d, input logic ab, input logic bz);
    total++;
    if ({grant, y, valid, done, aborted, busy} !== {g, ey, v, d, ab, bz}) begin
      bad++;
      $display("FAIL %s: got grant=%b y=%0d valid=%b done=%b aborted=%b busy=%b, want grant=%b y=%0d valid=%b done=%b aborted=%b busy=%b",
               name, grant, y, valid, done, aborted, busy, g, ey, v, d, ab, bz);
    end
  endtask

  initial begin
    // single run, len0 changed after latch
    add(2'b01, 4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    add(2'b01, 4'd7, 4'd0, 2'b01, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b01, 4'd7, 4'd0, 2'b01, 4'd1, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b01, 4'd7, 4'd0, 2'b01, 4'd2, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b01, 4'd7, 4'd0, 2'b01, 4'd2, 1'b0, 2'b01, 1'b0, 1'b1);
    add(2'b00, 4'd7, 4'd0, 2'b00, 4'd2, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b00, 4'd2, 4'd2, 2'b00, 4'd2, 1'b0, 2'b00, 1'b0, 1'b0);
    // round robin, both requesting
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd2, 1'b0, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd1, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd1, 1'b0, 2'b10, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b00, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b11, 4'd2, 4'd2, 2'b01, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b01, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b01, 4'd1, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b01, 4'd1, 1'b0, 2'b01, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b00, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd1, 1'b1, 2'b00, 1'b0, 1'b1);
    add(2'b11, 4'd2, 4'd2, 2'b10, 4'd1, 1'b0, 2'b10, 1'b0, 1'b1);
    add(2'b01, 4'd2, 4'd2, 2'b00, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0);
    // request dropped during CLEAR
    add(2'b01, 4'd2, 4'd2, 2'b01, 4'd1, 1'b0, 2'b00, 1'b0, 1'b1);
    add(2'b00, 4'd2, 4'd2, 2'b01, 4'd0, 1'b0, 2'b01, 1'b1, 1'b1);
    add(2'b00, 4'd2, 4'd2, 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);

    // reset held with both requesting
    reset = 1'b0; req = 2'b11; len0 = 4'd1; len1 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("reset_hold", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("first_grant", 2'b01, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1 reset = 1'b0;
    #1 chk("async_reset_clear", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step(2'b00, 4'd0, 4'd0);
    chk("reset_low_idle", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_idle", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].len0, vecs[i].len1);
      chk($sformatf("vec%0d", i), vecs[i].grant, vecs[i].y, vecs[i].valid,
          vecs[i].done, vecs[i].aborted, vecs[i].busy);
    end

    // full wrap with len1 = 0
    step(2'b10, 4'd0, 4'd0);
    chk("wrap_clear", 2'b10, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(2'b10, 4'd0, 4'd5);
      chk($sformatf("wrap_run%0d", i), 2'b10, 4'(i), 1'b1, 2'b00, 1'b0, 1'b1);
    end
    step(2'b10, 4'd0, 4'd5);
    chk("wrap_done", 2'b10, 4'd15, 1'b0, 2'b10, 1'b0, 1'b1);
    step(2'b00, 4'd0, 4'd0);
    chk("wrap_idle_hold", 2'b00, 4'd15, 1'b0, 2'b00, 1'b0, 1'b0);

    // abort after y = 2
    step(2'b01, 4'd8, 4'd0);
    chk("abort_clear", 2'b01, 4'd15, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 4'd8, 4'd0);
      chk($sformatf("abort_run%0d", i), 2'b01, 4'(i), 1'b1, 2'b00, 1'b0, 1'b1);
    end
    step(2'b00, 4'd8, 4'd0);
    chk("abort_done", 2'b01, 4'd2, 1'b0, 2'b01, 1'b1, 1'b1);
    step(2'b00, 4'd8, 4'd0);
    chk("abort_idle", 2'b00, 4'd2, 1'b0, 2'b00, 1'b0, 1'b0);

    // reset mid-run at y = 5
    step(2'b01, 4'd8, 4'd0);
    chk("midrst_clear", 2'b01, 4'd2, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(2'b01, 4'd8, 4'd0);
      chk($sformatf("midrst_run%0d", i), 2'b01, 4'(i), 1'b1, 2'b00, 1'b0, 1'b1);
    end
    #1 reset = 1'b0;
    #1 chk("midrst_async", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(2'b01, 4'd8, 4'd0);
      chk("midrst_no_done", 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clock); req = 2'b11; reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_regrant", 2'b01, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
